br_credit_flow_scheduler: RTL

- Shares one credit pool and one credit/valid pop link among NumFlows ready/valid push requesters.
- Arbitrates round-robin, sends one flit per cycle with its flow id, and tracks credits returned by the receiver.
- Sits between per-flow sources and a single-link credit receiver.
- Also sequences link reset and initialisation: sender-in-reset handshake and initial credit load.

---
 rtl/br_credit_flow_scheduler.sv | 106 ++++++++++
 1 files changed

// File: rtl/br_credit_flow_scheduler.sv
// br_credit_flow_scheduler: round-robin arbiter of NumFlows push requesters onto one credit/valid link
// with a shared credit pool and sender/receiver reset-init sequencing.
module br_credit_flow_scheduler #(
  parameter int NumFlows = 2,
  parameter int Width = 8,
  parameter int MaxCredit = 4,
  parameter int PopCreditMaxChange = 1,
  localparam int FW = $clog2(NumFlows),
  localparam int CW = $clog2(MaxCredit + 1),
  localparam int PW = $clog2(PopCreditMaxChange + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NumFlows-1:0]       push_valid,
  output logic [NumFlows-1:0]       push_ready,
  input  logic [NumFlows*Width-1:0] push_data,
  output logic                      pop_sender_in_reset,
  input  logic                      pop_receiver_in_reset,
  input  logic [PW-1:0]             pop_credit,
  output logic                      pop_valid,
  output logic [Width-1:0]          pop_data,
  output logic [FW-1:0]             pop_flow_id,
  input  logic [CW-1:0]             credit_initial,
  input  logic [CW-1:0]             credit_withhold,
  output logic [CW-1:0]             credit_count,
  output logic [CW-1:0]             credit_available
);
  typedef enum logic [1:0] {RESET_HOLD, INIT, ACTIVE} state_t;
  localparam logic [FW:0] NF = (FW+1)'(NumFlows);
  localparam logic [CW:0] MC = (CW+1)'(MaxCredit);
  state_t state, state_nx;
  logic [FW-1:0] ptr, gnt_id, ptr_nx;
  logic [FW:0] idx, nxt;
  logic gnt_any, hs;
  logic [CW:0] cnt_sum;
  logic [CW-1:0] cnt_nx;
  assign credit_available = (credit_count > credit_withhold) ? credit_count - credit_withhold : '0;
  // scan from the highest offset down so the nearest requester after ptr wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int i = NumFlows - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (FW+1)'(i);
      idx = (idx >= NF) ? idx - NF : idx;
      if (push_valid[idx[FW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id = idx[FW-1:0];
      end
    end
  end
  assign hs = (state == ACTIVE) && !pop_receiver_in_reset && (credit_available != '0) && gnt_any;
  assign push_ready = hs ? (NumFlows)'(1) << gnt_id : '0;
  assign nxt = {1'b0, gnt_id} + (FW+1)'(1);
  assign ptr_nx = (nxt == NF) ? '0 : nxt[FW-1:0];
  assign cnt_sum = {1'b0, credit_count} + (CW+1)'(pop_credit) - (CW+1)'(hs);
  assign cnt_nx = (cnt_sum > MC) ? CW'(MaxCredit) : cnt_sum[CW-1:0];
  always_comb begin
    state_nx = (state == RESET_HOLD) ? (pop_receiver_in_reset ? RESET_HOLD : INIT) :
               (state == INIT) ? ACTIVE : (pop_receiver_in_reset ? RESET_HOLD : ACTIVE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_HOLD;
      credit_count <= '0;
      pop_valid <= 1'b0;
      pop_data <= '0;
      pop_flow_id <= '0;
      pop_sender_in_reset <= 1'b1;
      ptr <= '0;
    end else begin
      state <= state_nx;
      pop_valid <= hs;
      if (hs) begin
        pop_data <= push_data[gnt_id*Width +: Width];
        pop_flow_id <= gnt_id;
        ptr <= ptr_nx;
      end
      if (state == INIT) begin
        credit_count <= credit_initial;
        pop_sender_in_reset <= 1'b0;
      end else if (state == ACTIVE && pop_receiver_in_reset) begin
        credit_count <= '0;
        pop_sender_in_reset <= 1'b1;
      end else if (state == ACTIVE) begin
        credit_count <= cnt_nx;
      end
    end
  end
`ifndef SYNTHESIS
  int outstanding;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) outstanding <= 0;
    else if (state == INIT) outstanding <= 0;
    else if (state == ACTIVE && !pop_receiver_in_reset) outstanding <= outstanding + int'(hs) - int'(pop_credit);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(push_ready));
      assert (!pop_valid || state == ACTIVE);
      assert (state != ACTIVE || pop_receiver_in_reset || cnt_sum <= MC);
      assert (outstanding <= int'(credit_initial));
    end
  end
`endif
endmodule
